// File: rtl/add8_err_monitor.sv
// Error-statistics monitor for 8-bit approximate adders: compares each approximate sum
// with the exact sum over a programmed number of samples and accumulates MAE/WCE/EP data.
module add8_err_monitor #(
    parameter int W     = 8,
    parameter int CNT_W = 16,
    parameter int ACC_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             start,
    input  logic [CNT_W-1:0] target,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic [W:0]       in_o,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] n_samples,
    output logic [CNT_W-1:0] err_cnt,
    output logic [ACC_W-1:0] err_sum,
    output logic [W:0]       err_max,
    output logic [W-1:0]     wce_a,
    output logic [W-1:0]     wce_b,
    output logic             sat
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [CNT_W-1:0] ONE = 1;

    state_t           state;
    logic [CNT_W-1:0] tgt;
    logic [CNT_W-1:0] accepted;
    logic             s1_valid;
    logic [W-1:0]     s1_a;
    logic [W-1:0]     s1_b;
    logic [W:0]       s1_o;
    logic [W:0]       s1_exact;

    logic             accept;
    logic [W:0]       err;
    logic [ACC_W:0]   err_ext;
    logic [ACC_W:0]   sum_ext;

    assign in_ready = (state == RUN) && (accepted < tgt);
    assign accept   = in_valid && in_ready;
    assign busy     = (state == RUN) || (state == DRAIN);
    assign done     = (state == DONE);

    // S2 datapath: absolute error and the widened accumulator sum used for saturation.
    always_comb begin
        err     = (s1_exact >= s1_o) ? (s1_exact - s1_o) : (s1_o - s1_exact);
        err_ext = (ACC_W+1)'(err);
        sum_ext = {1'b0, err_sum} + err_ext;
    end

    // NOTE: all state below uses non-blocking assignments so every register samples
    // pre-edge values; later assignments in the block deliberately override earlier ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            tgt       <= '0;
            accepted  <= '0;
            s1_valid  <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_o      <= '0;
            s1_exact  <= '0;
            n_samples <= '0;
            err_cnt   <= '0;
            err_sum   <= '0;
            err_max   <= '0;
            wce_a     <= '0;
            wce_b     <= '0;
            sat       <= 1'b0;
        end else if (clr) begin
            state     <= IDLE;
            tgt       <= '0;
            accepted  <= '0;
            s1_valid  <= 1'b0;
            n_samples <= '0;
            err_cnt   <= '0;
            err_sum   <= '0;
            err_max   <= '0;
            wce_a     <= '0;
            wce_b     <= '0;
            sat       <= 1'b0;
        end else begin
            // S1: capture operands and the exact (carry-extended) sum
            s1_valid <= accept;
            if (accept) begin
                s1_a     <= in_a;
                s1_b     <= in_b;
                s1_o     <= in_o;
                s1_exact <= {1'b0, in_a} + {1'b0, in_b};
                accepted <= accepted + ONE;
            end

            // S2: fold the sample into the statistics
            if (s1_valid) begin
                n_samples <= n_samples + ONE;
                if (err != '0) err_cnt <= err_cnt + ONE;
                if (sum_ext[ACC_W]) begin
                    err_sum <= '1;
                    sat     <= 1'b1;
                end else begin
                    err_sum <= sum_ext[ACC_W-1:0];
                end
                if (err > err_max) begin
                    err_max <= err;
                    wce_a   <= s1_a;
                    wce_b   <= s1_b;
                end
            end

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        tgt       <= target;
                        accepted  <= '0;
                        n_samples <= '0;
                        err_cnt   <= '0;
                        err_sum   <= '0;
                        err_max   <= '0;
                        wce_a     <= '0;
                        wce_b     <= '0;
                        sat       <= 1'b0;
                        state     <= (target != '0) ? RUN : DONE;
                    end
                end
                RUN: begin
                    if (accept && (accepted + ONE == tgt)) state <= DRAIN;
                end
                DRAIN: begin
                    // No new acceptances here, so an empty S1 means S2 has retired its last sample
                    if (!s1_valid) state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_add8_err_monitor.sv
// Directed bench for add8_err_monitor: default instance plus a 10-bit-accumulator
// instance sharing the same stimulus for the saturation case.
module tb_add8_err_monitor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic        start = 1'b0;
    logic [15:0] target = '0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_a = '0;
    logic [7:0]  in_b = '0;
    logic [8:0]  in_o = '0;

    logic        in_ready, busy, done, sat;
    logic [15:0] n_samples, err_cnt;
    logic [23:0] err_sum;
    logic [8:0]  err_max;
    logic [7:0]  wce_a, wce_b;

    logic        s_in_ready, s_busy, s_done, s_sat;
    logic [15:0] s_n_samples, s_err_cnt;
    logic [9:0]  s_err_sum;
    logic [8:0]  s_err_max;
    logic [7:0]  s_wce_a, s_wce_b;

    int checks = 0;
    int errors = 0;

    add8_err_monitor #(.W(8), .CNT_W(16), .ACC_W(24)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .start(start), .target(target),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_o(in_o),
        .busy(busy), .done(done), .n_samples(n_samples), .err_cnt(err_cnt),
        .err_sum(err_sum), .err_max(err_max), .wce_a(wce_a), .wce_b(wce_b), .sat(sat)
    );

    add8_err_monitor #(.W(8), .CNT_W(16), .ACC_W(10)) dut_s (
        .clk(clk), .rst_n(rst_n), .clr(clr), .start(start), .target(target),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_a(in_a), .in_b(in_b), .in_o(in_o),
        .busy(s_busy), .done(s_done), .n_samples(s_n_samples), .err_cnt(s_err_cnt),
        .err_sum(s_err_sum), .err_max(s_err_max), .wce_a(s_wce_a), .wce_b(s_wce_b), .sat(s_sat)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [15:0] t);
        start  = 1'b1;
        target = t;
        cyc();
        start  = 1'b0;
    endtask

    task automatic push(input string tag, input logic [7:0] a, input logic [7:0] b, input logic [8:0] o);
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_o = o;
        check({tag, "_ready"}, in_ready, 1);
        cyc();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        for (int i = 0; i < budget && done !== 1'b1; i++) cyc();
        check({tag, "_done"}, done, 1);
        check({tag, "_busy"}, busy, 0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ready"}, in_ready, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_n"}, n_samples, 0);
        check({tag, "_cnt"}, err_cnt, 0);
        check({tag, "_sum"}, err_sum, 0);
        check({tag, "_max"}, err_max, 0);
        check({tag, "_wa"}, wce_a, 0);
        check({tag, "_wb"}, wce_b, 0);
        check({tag, "_sat"}, sat, 0);
    endtask

    initial begin
        // Reset state
        #12;
        check_zero("rst_hold");
        @(posedge clk);
        #1 rst_n = 1'b1;
        cyc();
        check_zero("rst_idle");

        // Basic run: errors 8 and |510-503|=7
        start_run(2);
        check("basic_busy", busy, 1);
        push("basic0", 8'd0, 8'd0, 9'd8);
        push("basic1", 8'd255, 8'd255, 9'd503);
        wait_done("basic", 10);
        check("basic_n", n_samples, 2);
        check("basic_cnt", err_cnt, 2);
        check("basic_sum", err_sum, 15);
        check("basic_max", err_max, 8);
        check("basic_wa", wce_a, 0);
        check("basic_wb", wce_b, 0);
        check("basic_sat", sat, 0);

        // Exact sample and tie on worst-case error
        start_run(3);
        push("tie0", 8'd3, 8'd4, 9'd7);
        push("tie1", 8'd0, 8'd0, 9'd8);
        push("tie2", 8'd8, 8'd0, 9'd0);
        wait_done("tie", 10);
        check("tie_n", n_samples, 3);
        check("tie_cnt", err_cnt, 2);
        check("tie_sum", err_sum, 16);
        check("tie_max", err_max, 8);
        check("tie_wa", wce_a, 0);
        check("tie_wb", wce_b, 0);

        // Saturation: 3 x 511 = 1533 clamps to 1023 in a 10-bit accumulator
        start_run(3);
        push("sat0", 8'd0, 8'd0, 9'd511);
        push("sat1", 8'd0, 8'd0, 9'd511);
        push("sat2", 8'd0, 8'd0, 9'd511);
        wait_done("sat", 10);
        check("sat_s_sum", s_err_sum, 1023);
        check("sat_s_sat", s_sat, 1);
        check("sat_s_max", s_err_max, 511);
        check("sat_s_n", s_n_samples, 3);
        check("sat_wide_sum", err_sum, 1533);
        check("sat_wide_sat", sat, 0);

        // Target limit and backpressure, with an ignored start while busy
        start_run(3);
        in_valid = 1'b1; in_a = 8'd1; in_b = 8'd0; in_o = 9'd0;
        check("lim_c0_ready", in_ready, 1);
        cyc();
        in_valid = 1'b0; start = 1'b1; target = 16'd1;
        check("lim_c1_busy", busy, 1);
        cyc();
        start = 1'b0;
        in_valid = 1'b1; in_a = 8'd2;
        check("lim_c2_ready", in_ready, 1);
        cyc();
        in_a = 8'd3;
        check("lim_c3_ready", in_ready, 1);
        cyc();
        in_a = 8'd9;
        check("lim_c4_ready", in_ready, 0);
        check("lim_c4_busy", busy, 1);
        check("lim_c4_done", done, 0);
        cyc();
        check("lim_c5_ready", in_ready, 0);
        check("lim_c5_done", done, 0);
        cyc();
        check("lim_c6_done", done, 1);
        check("lim_c6_busy", busy, 0);
        in_valid = 1'b0;
        check("lim_n", n_samples, 3);
        check("lim_cnt", err_cnt, 3);
        check("lim_sum", err_sum, 6);
        check("lim_max", err_max, 3);
        check("lim_wa", wce_a, 3);

        // Zero target from DONE clears the previous stats
        start_run(0);
        check("zero_done", done, 1);
        check("zero_busy", busy, 0);
        check("zero_ready", in_ready, 0);
        check("zero_n", n_samples, 0);
        check("zero_sum", err_sum, 0);
        check("zero_max", err_max, 0);
        check("zero_wa", wce_a, 0);

        // clr one cycle after the first acceptance discards the in-flight sample
        start_run(3);
        push("clr0", 8'd0, 8'd0, 9'd100);
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        check_zero("clr_now");
        cyc();
        cyc();
        check_zero("clr_late");

        // Asynchronous reset mid-run with a sample sitting in S1
        start_run(5);
        push("arst0", 8'd0, 8'd0, 9'd50);
        push("arst1", 8'd0, 8'd0, 9'd20);
        check("arst_pre_sum", err_sum, 50);
        check("arst_pre_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check_zero("arst_now");
        @(posedge clk);
        #1 rst_n = 1'b1;
        cyc();
        cyc();
        cyc();
        check_zero("arst_after");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/add8_err_monitor.md
Name: add8_err_monitor

Overview:
Downstream characterisation stage for the 8-bit approximate adders. It consumes operand pairs plus the approximate adder's sum, computes the exact sum, and accumulates error statistics over a programmed number of samples. Tracked statistics are absolute-error sum, worst-case error with its operands, error-count and sample count. The stats feed the on-chip MAE/WCE/EP measurement flow.

Parameters:
W, 8, operand width; approximate and exact sums are W+1 bits
CNT_W, 16, width of target and sample/error counters
ACC_W, 24, width of absolute-error accumulator

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
clr  input  1  synchronous abort/clear, highest priority after reset
start  input  1  one-cycle pulse, begins a measurement run
target  input  CNT_W  number of samples to accept; sampled on start
in_valid  input  1  sample present
in_ready  output  1  block accepts a sample this cycle
in_a  input  W  operand A
in_b  input  W  operand B
in_o  input  W+1  approximate sum produced for (in_a, in_b)
busy  output  1  run in progress (RUN or DRAIN)
done  output  1  statistics final and stable
n_samples  output  CNT_W  samples accounted so far
err_cnt  output  CNT_W  samples with nonzero error
err_sum  output  ACC_W  sum of |exact - approx|, saturating
err_max  output  W+1  worst-case absolute error
wce_a  output  W  in_a of first sample reaching err_max
wce_b  output  W  in_b of first sample reaching err_max
sat  output  1  sticky, err_sum saturated this run

Behaviour:
- Reset (rst_n low, async): state IDLE; all outputs and pipeline valids 0.
- FSM states:
  - IDLE:
    - start with target!=0: latch target, zero all stats and sat, go to RUN.
    - start with target==0: zero stats, go to DONE.
  - RUN: in_ready = (accepted < target), combinational. A sample is accepted when in_valid & in_ready. When accepted == target, in_ready drops the cycle after the final acceptance and the FSM goes to DRAIN.
  - DRAIN: in_ready=0; wait until both pipeline stages are empty, then go to DONE.
  - DONE: done=1, stats held. start restarts exactly as from IDLE.
- start while busy is ignored. The target input is ignored except on an accepted start.
- clr in any state: go to IDLE; zero stats, sat, done and pipeline valids; in-flight samples are discarded. clr wins over a simultaneous start.
- Pipeline: 2 stages.
  - S1 registers a, b, o and exact = a + b (W+1 bits, no overflow).
  - S2 computes err = |exact - o| (W+1 bits, max 2^(W+1)-1) and updates the stats.
  - Stats are visible 2 cycles after acceptance. Full throughput of 1 sample/cycle.
- Update rules per S2-valid sample:
  - n_samples += 1.
  - err_cnt += 1 if err != 0.
  - err_sum += err, clamped to all-ones. sat is set if the true sum exceeds the clamp.
  - If err > err_max (strict), load err_max, wce_a and wce_b. Ties keep the earlier sample.
- busy = (state == RUN || state == DRAIN). done and busy are never both 1.
- Counters cannot wrap, because accepted samples ≤ target ≤ 2^CNT_W-1.

Test Plan:
- Reset: assert rst_n low mid-RUN with 1 sample in S1 -> immediately all outputs 0, in_ready=0, busy=0. After release, stays IDLE with no stats change.
- Basic run: target=2; send (a=0, b=0, o=8) then (a=255, b=255, o=503) -> done=1, n_samples=2, err_cnt=2, err_sum=15, err_max=8, wce_a=0, wce_b=0, sat=0.
- Exact sample and tie:
  - Setup: target=3; send (3,4,7), (0,0,8), (8,0,0).
  - Expected: err_cnt=2, err_sum=16, err_max=8, wce_a=0, wce_b=0 (tie keeps first).
- Saturation:
  - Setup: ACC_W=10; target=3; send 3× (a=0, b=0, o=511).
  - Expected: err_sum=1023, sat=1, err_max=511, n_samples=3.
- Target limit and backpressure:
  - Setup: target=3; hold in_valid high for 6 cycles, with a 1-cycle in_valid gap after the first sample.
  - Expected: exactly 3 accepted; in_ready low from the cycle after the 3rd acceptance; done asserted 2 cycles after DRAIN entry.
- clr / zero target:
  - clr one cycle after the first acceptance -> IDLE, all stats 0, no late update from the discarded sample.
  - start with target=0 -> done=1 the next cycle with all stats 0.
